if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 155 +++++++++++++++
 tb/tb_if_stage.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, imem handshake, skid buffer and IF/ID register.
// Define IF_MISALIGN_TRAP_EN to trap on misaligned redirect targets.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
`ifdef IF_MISALIGN_TRAP_EN
    output logic        fetch_misaligned,
`endif
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [4:0]  id_opcode
);

    localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef IF_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {FETCH, HOLD, DRAIN, TRAP} state_e;
`else
    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_e;
`endif

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic [31:0] id_pc_q, id_pc_d;

    logic [31:0] new_pc;
    state_e      redir_st;
    state_e      drain_st;

`ifdef IF_MISALIGN_TRAP_EN
    assign new_pc   = redirect_pc;
    assign redir_st = (|redirect_pc[1:0]) ? TRAP : FETCH;
    assign drain_st = (redirect ? |redirect_pc[1:0] : |tgt_q[1:0])
                    ? TRAP : FETCH;
    assign fetch_misaligned = (state_q == TRAP);
`else
    assign new_pc   = redirect_pc & 32'hFFFF_FFFC;
    assign redir_st = FETCH;
    assign drain_st = FETCH;
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        tgt_d       = tgt_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;
        id_valid_d  = id_valid_q & stall;
        id_inst_d   = id_inst_q;
        id_pc_d     = id_pc_q;
        case (state_q)
            FETCH: begin
                if (redirect) begin
                    id_valid_d = 1'b0;
                    if (imem_ready) begin
                        pc_d    = new_pc;
                        state_d = redir_st;
                    end else begin
                        tgt_d   = new_pc;
                        state_d = DRAIN;
                    end
                end else if (imem_ready) begin
                    pc_d = pc_q + 32'd4;
                    if (id_valid_q && stall) begin
                        skid_inst_d = imem_rdata;
                        skid_pc_d   = pc_q;
                        state_d     = HOLD;
                    end else begin
                        id_inst_d  = imem_rdata;
                        id_pc_d    = pc_q;
                        id_valid_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    id_valid_d = 1'b0;
                    pc_d       = new_pc;
                    state_d    = redir_st;
                end else if (!stall) begin
                    id_inst_d  = skid_inst_q;
                    id_pc_d    = skid_pc_q;
                    id_valid_d = 1'b1;
                    state_d    = FETCH;
                end
            end
            DRAIN: begin
                // Old request still owns the bus; its word is thrown away.
                id_valid_d = 1'b0;
                if (redirect) tgt_d = new_pc;
                if (imem_ready) begin
                    pc_d    = redirect ? new_pc : tgt_q;
                    state_d = drain_st;
                end
            end
`ifdef IF_MISALIGN_TRAP_EN
            TRAP: begin
                id_valid_d = 1'b0;
                if (redirect && !(|redirect_pc[1:0])) begin
                    pc_d    = new_pc;
                    state_d = FETCH;
                end
            end
`endif
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            tgt_q       <= RESET_PC;
            skid_inst_q <= NOP;
            skid_pc_q   <= 32'h0;
            id_valid_q  <= 1'b0;
            id_inst_q   <= NOP;
            id_pc_q     <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            tgt_q       <= tgt_d;
            skid_inst_q <= skid_inst_d;
            skid_pc_q   <= skid_pc_d;
            id_valid_q  <= id_valid_d;
            id_inst_q   <= id_inst_d;
            id_pc_q     <= id_pc_d;
        end
    end

    assign imem_req    = !rst && (state_q == FETCH || state_q == DRAIN);
    assign imem_addr   = pc_q;
    assign id_valid    = id_valid_q;
    assign id_inst     = id_inst_q;
    assign id_pc       = id_pc_q;
    assign id_pc_plus4 = id_pc_q + 32'd4;
    assign id_opcode   = id_inst_q[6:2];

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: stimulus queues expected fetch PCs,
// a monitor pops them whenever decode accepts an instruction.
module tb_if_stage;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [4:0]  id_opcode;
`ifdef IF_MISALIGN_TRAP_EN
    logic        fetch_misaligned;
`endif

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk),
        .rst(rst),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ready(imem_ready),
        .imem_rdata(imem_rdata),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
`ifdef IF_MISALIGN_TRAP_EN
        .fetch_misaligned(fetch_misaligned),
`endif
        .id_valid(id_valid),
        .id_inst(id_inst),
        .id_pc(id_pc),
        .id_pc_plus4(id_pc_plus4),
        .id_opcode(id_opcode)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: decode takes the instruction when valid, not stalled, not flushed.
    always @(negedge clk) begin
        logic [31:0] p;
        logic [31:0] ei;
        if (!rst && id_valid && !stall && !redirect) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL id_unexpected: got pc %h expected none", id_pc);
            end else begin
                p  = exp_q.pop_front();
                ei = p ^ K;
                chk("id_pc", id_pc, p);
                chk("id_inst", id_inst, ei);
                chk("id_pc_plus4", id_pc_plus4, p + 32'd4);
                chk("id_opcode", {27'b0, id_opcode}, {27'b0, ei[6:2]});
            end
        end
    end

    task automatic step(input logic rdy, input logic stl, input logic rd,
                        input logic [31:0] rpc);
        @(posedge clk);
        #1;
        imem_ready  = rdy;
        stall       = stl;
        redirect    = rd;
        redirect_pc = rpc;
        imem_rdata  = imem_addr ^ K;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        imem_ready = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        @(negedge clk);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_inst", id_inst, 32'h0000_0013);
        chk("rst_pc", id_pc, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
`ifdef IF_MISALIGN_TRAP_EN
        chk("rst_fm", {31'b0, fetch_misaligned}, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("post_rst_req", {31'b0, imem_req}, 32'd1);
        chk("post_rst_addr", imem_addr, 32'h0);
    endtask

    initial begin
        // Streaming fetch
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 32'h0);
            chk("stream_addr", imem_addr, 32'(4 * i));
            chk("stream_valid", {31'b0, id_valid}, (i > 0) ? 32'd1 : 32'd0);
            exp_q.push_back(32'(4 * i));
        end
        step(0, 0, 0, 32'h0);

        // Stall fills the skid buffer
        step(1, 0, 0, 32'h0);
        exp_q.push_back(32'h14);
        step(1, 1, 0, 32'h0);
        exp_q.push_back(32'h18);
        step(0, 1, 0, 32'h0);
        chk("skid_req", {31'b0, imem_req}, 32'd0);
        chk("skid_hold_pc", id_pc, 32'h14);
        step(0, 1, 0, 32'h0);
        chk("skid_req2", {31'b0, imem_req}, 32'd0);
        chk("skid_hold_valid", {31'b0, id_valid}, 32'd1);
        step(0, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0);
        chk("skid_next_addr", imem_addr, 32'h1C);
        chk("skid_next_req", {31'b0, imem_req}, 32'd1);

        // Redirect while request to 0x10 waits
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 32'h0);
            if (i < 3) exp_q.push_back(32'(4 * i));
        end
        step(0, 0, 1, 32'h100);
        chk("drain_old_addr", imem_addr, 32'h10);
        step(0, 0, 0, 32'h0);
        chk("drain_req", {31'b0, imem_req}, 32'd1);
        chk("drain_addr", imem_addr, 32'h10);
        chk("drain_valid", {31'b0, id_valid}, 32'd0);
        step(1, 0, 0, 32'h0);
        step(1, 0, 0, 32'h0);
        chk("drain_new_addr", imem_addr, 32'h100);
        chk("drain_new_valid", {31'b0, id_valid}, 32'd0);
        exp_q.push_back(32'h100);
        step(0, 0, 0, 32'h0);

        // Redirect + response + stall together
        step(1, 0, 0, 32'h0);
        step(1, 1, 1, 32'h100);
        chk("rr_valid_before", {31'b0, id_valid}, 32'd1);
        step(0, 0, 0, 32'h0);
        chk("rr_valid", {31'b0, id_valid}, 32'd0);
        chk("rr_addr", imem_addr, 32'h100);
        chk("rr_req", {31'b0, imem_req}, 32'd1);
        step(1, 0, 0, 32'h0);
        exp_q.push_back(32'h100);
        step(0, 0, 0, 32'h0);

        // Latest redirect wins during DRAIN
        step(0, 0, 1, 32'h300);
        step(0, 0, 1, 32'h400);
        chk("dd_addr", imem_addr, 32'h104);
        chk("dd_req", {31'b0, imem_req}, 32'd1);
        step(1, 0, 0, 32'h0);
        step(1, 0, 0, 32'h0);
        chk("dd_new_addr", imem_addr, 32'h400);
        exp_q.push_back(32'h400);
        step(0, 0, 0, 32'h0);

        // Redirect from HOLD
        step(1, 0, 0, 32'h0);
        step(1, 1, 0, 32'h0);
        step(0, 1, 1, 32'h500);
        chk("hr_req", {31'b0, imem_req}, 32'd0);
        step(0, 0, 0, 32'h0);
        chk("hr_addr", imem_addr, 32'h500);
        chk("hr_req2", {31'b0, imem_req}, 32'd1);
        chk("hr_valid", {31'b0, id_valid}, 32'd0);
        step(1, 0, 0, 32'h0);
        exp_q.push_back(32'h500);
        step(0, 0, 0, 32'h0);

        // PC wrap
        step(1, 0, 1, 32'hFFFF_FFFC);
        step(1, 0, 0, 32'h0);
        chk("wrap_addr_hi", imem_addr, 32'hFFFF_FFFC);
        exp_q.push_back(32'hFFFF_FFFC);
        step(1, 0, 0, 32'h0);
        chk("wrap_addr_lo", imem_addr, 32'h0);
        exp_q.push_back(32'h0);
        step(0, 0, 0, 32'h0);

        // Misaligned redirect
        step(1, 0, 1, 32'h102);
`ifdef IF_MISALIGN_TRAP_EN
        step(0, 0, 0, 32'h0);
        chk("trap_fm", {31'b0, fetch_misaligned}, 32'd1);
        chk("trap_req", {31'b0, imem_req}, 32'd0);
        chk("trap_valid", {31'b0, id_valid}, 32'd0);
        step(0, 0, 1, 32'h200);
        chk("trap_fm_hold", {31'b0, fetch_misaligned}, 32'd1);
        step(1, 0, 0, 32'h0);
        chk("trap_clr", {31'b0, fetch_misaligned}, 32'd0);
        chk("trap_addr", imem_addr, 32'h200);
        chk("trap_req2", {31'b0, imem_req}, 32'd1);
        exp_q.push_back(32'h200);
`else
        step(1, 0, 0, 32'h0);
        chk("mis_addr", imem_addr, 32'h100);
        chk("mis_req", {31'b0, imem_req}, 32'd1);
        exp_q.push_back(32'h100);
`endif
        step(0, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
